// File: rtl/idu_pkg.sv
// Shared types and sizing for the decode-side long-instruction scheduler.
// Each entry tracks one in-flight long op: its destination register and whether it writes it.
package idu_pkg;
    localparam int LONG_ID_NUM = 4;
    localparam int LONG_ID_W   = $clog2(LONG_ID_NUM);
    localparam int REG_ADDR_W  = 5;

    typedef struct packed {
        logic                  vld;
        logic                  rd_we;
        logic [REG_ADDR_W-1:0] rd;
    } long_ent_t;
endpackage

// File: rtl/idu_long_prio_enc.sv
// Lowest-free-index priority encoder over the entry valid vector.
// The index is 0 when every entry is occupied, so the full flag is reported separately.
module idu_long_prio_enc
    import idu_pkg::*;
(
    input  logic [LONG_ID_NUM-1:0] vld_i,
    output logic [LONG_ID_W-1:0]   free_idx_o,
    output logic                   full_o
);
    always_comb begin
        free_idx_o = '0;
        // Scan from the top so the lowest free index is the one left standing.
        for (int i = LONG_ID_NUM - 1; i >= 0; i--) begin
            if (!vld_i[i]) begin
                free_idx_o = LONG_ID_W'(i);
            end
        end
        full_o = &vld_i;
    end
endmodule

// File: rtl/idu_long_sched.sv
// Long-op scoreboard beside decode: allocates IDs to mul/div/load ops, releases them on commit,
// and stalls decode on RAW/WAW hazards against in-flight ops or when no ID is free.
module idu_long_sched
    import idu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dec_valid_i,
    input  logic                  dec_long_i,
    input  logic                  dec_rd_we_i,
    input  logic [REG_ADDR_W-1:0] dec_rd_i,
    input  logic                  dec_rs1_re_i,
    input  logic [REG_ADDR_W-1:0] dec_rs1_i,
    input  logic                  dec_rs2_re_i,
    input  logic [REG_ADDR_W-1:0] dec_rs2_i,
    input  logic                  ex_stall_i,
    input  logic                  flush_i,
    input  logic                  commit_valid_i,
    input  logic [LONG_ID_W-1:0]  commit_id_i,
    output logic                  hazard_stall_o,
    output logic                  issue_o,
    output logic [LONG_ID_W-1:0]  long_id_o,
    output logic                  long_id_valid_o,
    output logic [LONG_ID_W:0]    pending_cnt_o,
    output logic                  idle_o,
    output logic                  commit_err_o
);
    long_ent_t ent_q [LONG_ID_NUM];
    long_ent_t ent_d [LONG_ID_NUM];
    logic      commit_err_q;
    logic      commit_err_d;

    logic [LONG_ID_NUM-1:0] vld;
    logic [LONG_ID_NUM-1:0] rel;
    logic [LONG_ID_NUM-1:0] act;
    logic [LONG_ID_W-1:0]   free_idx;
    logic                   all_busy;
    logic                   raw;
    logic                   waw;
    logic                   alloc;
    logic [LONG_ID_W:0]     cnt;

    always_comb begin
        for (int i = 0; i < LONG_ID_NUM; i++) begin
            vld[i] = ent_q[i].vld;
        end
    end

    idu_long_prio_enc u_prio_enc (
        .vld_i      (vld),
        .free_idx_o (free_idx),
        .full_o     (all_busy)
    );

    always_comb begin
        raw = 1'b0;
        waw = 1'b0;
        cnt = '0;
        for (int i = 0; i < LONG_ID_NUM; i++) begin
            rel[i] = commit_valid_i && (commit_id_i == LONG_ID_W'(i)) && vld[i];
            // A same-cycle commit retires the entry before the hazard compare.
            act[i] = vld[i] && !rel[i];
            // rd_we is stored already masked with rd!=0, so x0 writers never match.
            if (act[i] && ent_q[i].rd_we) begin
                if ((dec_rs1_re_i && (dec_rs1_i == ent_q[i].rd)) ||
                    (dec_rs2_re_i && (dec_rs2_i == ent_q[i].rd))) begin
                    raw = 1'b1;
                end
                if (dec_rd_we_i && (dec_rd_i == ent_q[i].rd)) begin
                    waw = 1'b1;
                end
            end
            cnt = cnt + {{LONG_ID_W{1'b0}}, vld[i]};
        end

        hazard_stall_o  = dec_valid_i && !flush_i && (raw || waw || (dec_long_i && all_busy));
        issue_o         = dec_valid_i && !flush_i && !ex_stall_i && !hazard_stall_o;
        alloc           = issue_o && dec_long_i;
        long_id_o       = free_idx;
        long_id_valid_o = alloc;
        pending_cnt_o   = cnt;
        idle_o          = ~|vld;
        commit_err_o    = commit_err_q;
    end

    always_comb begin
        commit_err_d = commit_err_q || (commit_valid_i && !vld[commit_id_i]);
        for (int i = 0; i < LONG_ID_NUM; i++) begin
            ent_d[i] = ent_q[i];
            if (rel[i]) begin
                ent_d[i].vld = 1'b0;
            end
            // The free index comes from registered vld, so it never aliases a releasing entry.
            if (alloc && (free_idx == LONG_ID_W'(i))) begin
                ent_d[i].vld   = 1'b1;
                ent_d[i].rd_we = dec_rd_we_i && (dec_rd_i != '0);
                ent_d[i].rd    = dec_rd_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LONG_ID_NUM; i++) begin
                ent_q[i] <= '0;
            end
            commit_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < LONG_ID_NUM; i++) begin
                ent_q[i] <= ent_d[i];
            end
            commit_err_q <= commit_err_d;
        end
    end
endmodule

// File: tb/tb_idu_long_sched.sv
// Scoreboard bench for idu_long_sched: a driver pushes expected outputs from a behavioural
// model of the in-flight table; a monitor pops and compares each cycle.
module tb_idu_long_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dec_valid_i = 0, dec_long_i = 0, dec_rd_we_i = 0;
    logic [4:0] dec_rd_i = '0, dec_rs1_i = '0, dec_rs2_i = '0;
    logic       dec_rs1_re_i = 0, dec_rs2_re_i = 0;
    logic       ex_stall_i = 0, flush_i = 0, commit_valid_i = 0;
    logic [1:0] commit_id_i = '0;
    logic       hazard_stall_o, issue_o, long_id_valid_o, idle_o, commit_err_o;
    logic [1:0] long_id_o;
    logic [2:0] pending_cnt_o;

    idu_long_sched dut (
        .clk(clk), .rst_n(rst_n),
        .dec_valid_i(dec_valid_i), .dec_long_i(dec_long_i), .dec_rd_we_i(dec_rd_we_i),
        .dec_rd_i(dec_rd_i), .dec_rs1_re_i(dec_rs1_re_i), .dec_rs1_i(dec_rs1_i),
        .dec_rs2_re_i(dec_rs2_re_i), .dec_rs2_i(dec_rs2_i),
        .ex_stall_i(ex_stall_i), .flush_i(flush_i),
        .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
        .hazard_stall_o(hazard_stall_o), .issue_o(issue_o), .long_id_o(long_id_o),
        .long_id_valid_o(long_id_valid_o), .pending_cnt_o(pending_cnt_o),
        .idle_o(idle_o), .commit_err_o(commit_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       stall, issue, idv, idle, err;
        bit [1:0] id;
        int       pend;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Model of the in-flight table: which IDs are taken and what they will write.
    bit       m_busy [4];
    bit [4:0] m_rd   [4];
    bit       m_we   [4];
    bit       m_err;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            m_busy[i] = 0; m_rd[i] = '0; m_we[i] = 0;
        end
        m_err = 0;
    endtask

    // One decode cycle: apply inputs, predict outputs, then advance the model.
    task automatic cyc(input bit v, input bit lng, input bit we, input int rd,
                       input bit r1e, input int r1, input bit r2e, input int r2,
                       input bit exs, input bit fl, input bit cv, input int cid);
        exp_t e;
        bit   blocked, full, gone;
        int   cnt, free;
        @(negedge clk);
        dec_valid_i = v; dec_long_i = lng; dec_rd_we_i = we; dec_rd_i = 5'(rd);
        dec_rs1_re_i = r1e; dec_rs1_i = 5'(r1); dec_rs2_re_i = r2e; dec_rs2_i = 5'(r2);
        ex_stall_i = exs; flush_i = fl; commit_valid_i = cv; commit_id_i = 2'(cid);

        blocked = 0; cnt = 0; free = -1;
        for (int i = 0; i < 4; i++) begin
            gone = cv && (cid == i);
            if (m_busy[i] && !gone && m_we[i] && m_rd[i] != 0) begin
                if ((r1e && r1 == m_rd[i]) || (r2e && r2 == m_rd[i]) || (we && rd == m_rd[i]))
                    blocked = 1;
            end
            if (m_busy[i]) cnt++;
            else if (free < 0) free = i;
        end
        full = (cnt == 4);
        e.stall = v && !fl && (blocked || (lng && full));
        e.issue = v && !fl && !exs && !e.stall;
        e.idv   = e.issue && lng;
        e.id    = (free < 0) ? 2'd0 : 2'(free);
        e.pend  = cnt;
        e.idle  = (cnt == 0);
        e.err   = m_err;
        q.push_back(e);

        if (cv) begin
            if (m_busy[cid]) m_busy[cid] = 0;
            else m_err = 1;
        end
        if (e.idv) begin
            m_busy[free] = 1; m_rd[free] = 5'(rd); m_we[free] = we;
        end
    endtask

    task automatic nop(input bit cv = 0, input int cid = 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cv, cid);
    endtask

    task automatic long_op(input int rd, input bit cv = 0, input int cid = 0);
        cyc(1, 1, 1, rd, 0, 0, 0, 0, 0, 0, cv, cid);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("hazard_stall", int'(hazard_stall_o), int'(e.stall));
            chk("issue", int'(issue_o), int'(e.issue));
            chk("long_id_valid", int'(long_id_valid_o), int'(e.idv));
            if (e.idv) chk("long_id", int'(long_id_o), int'(e.id));
            chk("pending_cnt", int'(pending_cnt_o), e.pend);
            chk("idle", int'(idle_o), int'(e.idle));
            chk("commit_err", int'(commit_err_o), int'(e.err));
        end
    end

    initial begin
        int t;
        model_clear();
        repeat (2) @(negedge clk);
        chk("rst_stall", int'(hazard_stall_o), 0);
        chk("rst_issue", int'(issue_o), 0);
        chk("rst_idv", int'(long_id_valid_o), 0);
        chk("rst_id", int'(long_id_o), 0);
        chk("rst_pend", int'(pending_cnt_o), 0);
        chk("rst_idle", int'(idle_o), 1);
        chk("rst_err", int'(commit_err_o), 0);
        rst_n = 1'b1;

        // RAW against x5, then same-cycle commit bypass.
        long_op(5);
        cyc(1, 0, 1, 9, 1, 5, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 9, 1, 5, 0, 0, 0, 0, 1, 0);
        nop();

        // Fill all IDs; commit relieves full only on the following cycle.
        long_op(1); long_op(2); long_op(3); long_op(4);
        long_op(6);
        long_op(6, 1, 2);
        long_op(6);
        for (int i = 0; i < 4; i++) nop(1, i);

        // WAW on x7, then an x0 writer that creates no hazard.
        long_op(7);
        cyc(1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        long_op(0);
        cyc(1, 0, 1, 3, 1, 0, 1, 0, 0, 0, 0, 0);
        nop(1, 0); nop(1, 1);

        // Flush and ex_stall block allocation without stalling.
        cyc(1, 1, 1, 8, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc(1, 1, 1, 8, 0, 0, 0, 0, 1, 0, 0, 0);
        nop();

        // Randomized traffic with mostly legal commits.
        for (int n = 0; n < 1500; n++) begin
            int cid; bit cv;
            cv = 0; cid = 0;
            for (int k = 0; k < 4; k++) begin
                t = int'($urandom_range(0, 3));
                if (m_busy[t] && ($urandom_range(0, 2) == 0)) begin cv = 1; cid = t; break; end
            end
            if ($urandom_range(0, 99) == 0) begin cv = 1; cid = int'($urandom_range(0, 3)); end
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                $urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
                $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, cv, cid);
        end

        // Async reset with several entries live, then commit errors on the empty table.
        long_op(10); long_op(11); long_op(12);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_pend", int'(pending_cnt_o), 0);
        chk("async_idle", int'(idle_o), 1);
        chk("async_err", int'(commit_err_o), 0);
        model_clear();
        #1 rst_n = 1'b1;
        nop(1, 3);
        nop(); nop();
        long_op(13); nop(1, 0);

        nop();
        t = 0;
        while (q.size() > 0 && t < 20) begin @(negedge clk); t++; end
        #3;
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
